// File: rtl/ervp_radix_divider.sv
// Restoring radix-2^BITS_PER_CYCLE integer divider (signed/unsigned) returning an opaque tag with the result.
// Latency: result visible right after the accept edge for x/0, MIN/-1 and |n|<|d|; otherwise after K iteration edges.
// Backpressure: result holds in DONE until rsp_ready; enable=0 freezes all state, abort flushes to IDLE.
module ervp_radix_divider #(
    parameter int BW_DATA        = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter int EARLY_OUT      = 1,
    parameter int BW_TAG         = 4
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               enable,
    input  logic               abort,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_is_unsigned,
    input  logic [BW_DATA-1:0] req_numerator,
    input  logic [BW_DATA-1:0] req_denominator,
    input  logic [BW_TAG-1:0]  req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [BW_DATA-1:0] rsp_quotient,
    output logic [BW_DATA-1:0] rsp_remainder,
    output logic [BW_TAG-1:0]  rsp_tag,
    output logic               busy
);
    localparam int NUM_GROUP = BW_DATA / BITS_PER_CYCLE;
    localparam int BW_CNT    = $clog2(NUM_GROUP + 1);
    localparam int BW_IDX    = $clog2(BW_DATA);
    localparam int LOG_BPC   = $clog2(BITS_PER_CYCLE);
    localparam logic [BW_DATA-1:0] MIN_VAL = {1'b1, {(BW_DATA-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [BW_CNT-1:0]  iter_cnt;
    logic [BW_DATA-1:0] dvs_mag;
    logic [BW_DATA-1:0] nq;
    logic [BW_DATA-1:0] rem;
    logic               neg_q;
    logic               neg_r;

    logic               accept;
    logic               req_signed;
    logic               num_neg;
    logic               den_neg;
    logic               den_zero;
    logic               ovf_case;
    logic               small_case;
    logic [BW_DATA-1:0] num_mag;
    logic [BW_DATA-1:0] den_mag;
    logic [BW_IDX-1:0]  msb_idx;
    logic [BW_CNT-1:0]  k_early;
    logic [BW_CNT-1:0]  k_load;
    int                 pre_shift;

    logic [BW_DATA:0]   step_rem;
    logic [BW_DATA-1:0] step_nq;
    logic [BW_DATA-1:0] fin_quo;
    logic [BW_DATA-1:0] fin_rem;

    assign busy      = (state == CALC);
    assign rsp_valid = (state == DONE);
    assign req_ready = enable & ~abort & ((state == IDLE) | ((state == DONE) & rsp_ready));
    assign accept    = req_valid & req_ready;

    always_comb begin : decode
        req_signed = ~req_is_unsigned;
        num_neg    = req_signed & req_numerator[BW_DATA-1];
        den_neg    = req_signed & req_denominator[BW_DATA-1];
        num_mag    = num_neg ? -req_numerator : req_numerator;
        den_mag    = den_neg ? -req_denominator : req_denominator;
        den_zero   = (req_denominator == '0);
        ovf_case   = req_signed && (req_numerator == MIN_VAL) && (req_denominator == '1);
        small_case = (num_mag < den_mag);
        msb_idx    = '0;
        for (int i = 0; i < BW_DATA; i++) begin
            if (num_mag[i]) msb_idx = BW_IDX'(i);
        end
        k_early   = BW_CNT'(msb_idx >> LOG_BPC) + BW_CNT'(1);
        k_load    = (EARLY_OUT != 0) ? k_early : BW_CNT'(NUM_GROUP);
        // Left-align the significant digit groups so skipped groups are never iterated.
        pre_shift = (NUM_GROUP - int'(k_load)) * BITS_PER_CYCLE;
    end

    // Quotient bits shift into the bottom of nq as numerator bits leave the top.
    always_comb begin : iterate
        step_rem = {1'b0, rem};
        step_nq  = nq;
        for (int s = 0; s < BITS_PER_CYCLE; s++) begin
            step_rem = {step_rem[BW_DATA-1:0], step_nq[BW_DATA-1]};
            step_nq  = {step_nq[BW_DATA-2:0], 1'b0};
            if (step_rem >= {1'b0, dvs_mag}) begin
                step_rem   = step_rem - {1'b0, dvs_mag};
                step_nq[0] = 1'b1;
            end
        end
        fin_quo = neg_q ? -step_nq : step_nq;
        fin_rem = neg_r ? -step_rem[BW_DATA-1:0] : step_rem[BW_DATA-1:0];
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state         <= IDLE;
            iter_cnt      <= '0;
            dvs_mag       <= '0;
            nq            <= '0;
            rem           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_tag       <= '0;
        end else if (enable) begin
            if (abort) begin
                state    <= IDLE;
                iter_cnt <= '0;
            end else begin
                case (state)
                    CALC: begin
                        rem      <= step_rem[BW_DATA-1:0];
                        nq       <= step_nq;
                        iter_cnt <= iter_cnt - BW_CNT'(1);
                        if (iter_cnt == BW_CNT'(1)) begin
                            state         <= DONE;
                            rsp_quotient  <= fin_quo;
                            rsp_remainder <= fin_rem;
                        end
                    end
                    DONE: begin
                        if (rsp_ready) state <= IDLE;
                    end
                    default: ;
                endcase
                if (accept) begin
                    rsp_tag <= req_tag;
                    neg_q   <= req_signed & (num_neg ^ den_neg);
                    neg_r   <= num_neg;
                    if (den_zero) begin
                        state         <= DONE;
                        iter_cnt      <= '0;
                        rsp_quotient  <= '1;
                        rsp_remainder <= req_numerator;
                    end else if (ovf_case) begin
                        state         <= DONE;
                        iter_cnt      <= '0;
                        rsp_quotient  <= MIN_VAL;
                        rsp_remainder <= '0;
                    end else if (small_case) begin
                        state         <= DONE;
                        iter_cnt      <= '0;
                        rsp_quotient  <= '0;
                        rsp_remainder <= req_numerator;
                    end else begin
                        state    <= CALC;
                        iter_cnt <= k_load;
                        dvs_mag  <= den_mag;
                        nq       <= num_mag << pre_shift;
                        rem      <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: doc/ervp_radix_divider.md
ERVP_RADIX_DIVIDER -- requirements
Module: ervp_radix_divider

Interface
REQ-001 SHALL have parameter BW_DATA, default 32, operand/result width; multiple of BITS_PER_CYCLE, >=8.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 2, quotient bits retired per iteration; legal values 1, 2, 4.
REQ-003 SHALL have parameter EARLY_OUT, default 1; 1 = skip leading-zero numerator digit groups, 0 = fixed iteration count.
REQ-004 SHALL have parameter BW_TAG, default 4, width of the request tag returned with the result.
REQ-005 SHALL have ports:
  clk  input  1  clock, rising edge;
  rstnn  input  1  reset, asynchronous, active-low;
  enable  input  1  global stall; 0 freezes all state;
  abort  input  1  synchronous flush to IDLE;
  req_valid  input  1  request present;
  req_ready  output  1  request accepted when req_valid&req_ready&enable;
  req_is_unsigned  input  1  1 = unsigned, 0 = two's-complement;
  req_numerator  input  BW_DATA  dividend;
  req_denominator  input  BW_DATA  divisor;
  req_tag  input  BW_TAG  opaque tag;
  rsp_valid  output  1  result present;
  rsp_ready  input  1  result consumed when rsp_valid&rsp_ready&enable;
  rsp_quotient  output  BW_DATA  quotient;
  rsp_remainder  output  BW_DATA  remainder;
  rsp_tag  output  BW_TAG  tag of the request;
  busy  output  1  high in CALC.

Function
REQ-006 SHALL implement states IDLE, CALC, DONE; transitions occur only on edges with enable=1.
REQ-007 req_ready SHALL equal enable & ~abort & (IDLE | (DONE & rsp_ready)); back-to-back requests SHALL be accepted on the same edge that retires a response.
REQ-008 On acceptance the block SHALL capture operand magnitudes, result signs, and tag; inputs SHALL then be don't-care.
REQ-009 Special cases SHALL go directly to DONE at the acceptance edge, giving rsp_valid 1 edge after acceptance:
  denominator==0 -> quotient all-ones, remainder = numerator;
  signed, numerator==MIN, denominator==-1 -> quotient MIN, remainder 0;
  |numerator| < |denominator| -> quotient 0, remainder = numerator.
REQ-010 Otherwise the block SHALL enter CALC and perform K iterations, one per enabled cycle, each doing a restoring radix-2^BITS_PER_CYCLE step (BITS_PER_CYCLE chained compare/subtract stages); DONE is entered on the K-th iteration edge.
REQ-011 K SHALL be BW_DATA/BITS_PER_CYCLE when EARLY_OUT=0; when EARLY_OUT=1, K = ceil(significant bits of |numerator| / BITS_PER_CYCLE), minimum 1.
REQ-012 Quotient SHALL be negated when signed and operand signs differ; remainder SHALL carry the numerator's sign; unsigned mode SHALL apply no sign processing.
REQ-013 Results SHALL truncate toward zero and satisfy numerator = quotient*denominator + remainder modulo 2^BW_DATA for all non-zero-divisor cases.
REQ-014 rsp_quotient, rsp_remainder, and rsp_tag SHALL be registered and held stable while rsp_valid=1 and the result has not been consumed.
REQ-015 Consumption without a new request SHALL return the state to IDLE and deassert rsp_valid on that edge.
REQ-016 abort=1 with enable=1 SHALL force IDLE from any state, drop any in-flight or pending result, and accept no request on that edge.
REQ-017 enable=0 SHALL hold all state, outputs, and the iteration count unchanged; req_ready SHALL be 0.

Reset
REQ-018 rstnn=0 SHALL asynchronously force IDLE, iteration counter 0, rsp_valid 0, busy 0, and rsp_quotient/rsp_remainder/rsp_tag 0, including mid-CALC; req_ready follows REQ-007 once rstnn=1.

Verification
REQ-019 Unsigned 100/7, tag 3, BW_DATA=32, BITS_PER_CYCLE=2, EARLY_OUT=0 -> rsp_valid 16 edges after acceptance; quotient 14, remainder 2, tag 3.
REQ-020 Signed -7/2 -> quotient -3 (0xFFFFFFFD), remainder -1; signed 0x80000000/-1 -> quotient 0x80000000, remainder 0, 1-edge latency.
REQ-021 x/0 with x=0x1234 -> quotient 0xFFFFFFFF, remainder 0x1234; 5/9 -> quotient 0, remainder 5; both 1-edge latency.
REQ-022 EARLY_OUT=1, BITS_PER_CYCLE=4, unsigned 0x000000FF/3 -> K=2; quotient 0x55, remainder 0.
REQ-023 rsp_ready=0 for 10 cycles -> outputs stable; then rsp_ready=1 with a new req_valid -> response retired and new request accepted on the same edge; enable toggled mid-CALC -> latency extended by the number of enable=0 cycles, results unchanged.
REQ-024 abort at iteration 5, and separately rstnn low mid-CALC -> IDLE next edge (immediately for reset), no response, busy 0; the next request completes correctly.
